// File: rtl/pool_max_stream.sv
// pool_max_stream: streaming FP16 max-pooling engine.
// Pops pre-windowed FP16 activations from a first-word-fall-through data
// FIFO, reduces each window of win_len elements to its maximum and offers
// each result to the write-back FIFO. After op_num results it reports done.
// Optional feature macro: POOL_RELU_EN (negative non-NaN results become +0).
//
// Handshakes: on the output side a transfer happens on a rising clk edge
// where dout_valid and dout_ready are both high; while dout_valid is high
// and dout_ready is low, dout is held stable. On the input side a pop
// happens on a rising clk edge where data_fifo_rd_en is high and din_empty
// is low; din is the FIFO head and is consumed by that edge.
module pool_max_stream #(
    parameter int DW = 16,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          maxpool_ready,
    output logic          maxpool_valid,
    input  logic [7:0]    win_len,
    input  logic [CW-1:0] op_num,
    input  logic [DW-1:0] din,
    input  logic          din_empty,
    output logic          data_fifo_rd_en,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [7:0]    win_q;
    logic [CW-1:0] op_q;
    logic [7:0]    elem_cnt;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_cnt_inc;
    logic [DW-1:0] acc;

    logic          pop;
    logic          accept;
    logic          last_elem;
    logic [DW-1:0] max_next;
    logic [DW-1:0] result;

    // NaN: exponent all ones with a non-zero mantissa.
    function automatic logic is_nan(input logic [DW-1:0] x);
        return (x[DW-2:DW-6] == 5'h1f) && (x[DW-7:0] != '0);
    endfunction

    // True when cand strictly beats cur. Ties (including +0 vs -0) keep cur,
    // so the earlier element of the window wins. A NaN already held wins
    // over everything, a new NaN wins over any non-NaN.
    function automatic logic beats(input logic [DW-1:0] cand, input logic [DW-1:0] cur);
        logic [DW-2:0] cm;
        logic [DW-2:0] um;
        logic          r;
        cm = cand[DW-2:0];
        um = cur[DW-2:0];
        if (is_nan(cur))
            r = 1'b0;
        else if (is_nan(cand))
            r = 1'b1;
        else if ((cm == '0) && (um == '0))
            r = 1'b0;
        else if (cand[DW-1] != cur[DW-1])
            r = ~cand[DW-1];
        else if (!cand[DW-1])
            r = (cm > um);
        else
            r = (cm < um);
        return r;
    endfunction

    assign pop         = (state_q == ST_RUN) && !din_empty;
    assign accept      = (state_q == ST_OUT) && dout_ready;
    assign last_elem   = (elem_cnt == (win_q - 8'd1));
    assign out_cnt_inc = out_cnt + CW'(1);

    // Running maximum including the element popped this cycle.
    always_comb begin
        max_next = acc;
        if (elem_cnt == 8'd0)
            max_next = din;
        else if (beats(din, acc))
            max_next = din;
    end

    // Value written to dout at the end of a window.
    always_comb begin
        result = max_next;
`ifdef POOL_RELU_EN
        if (max_next[DW-1] && !is_nan(max_next))
            result = '0;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; a falling maxpool_ready aborts RUN/OUT without done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (maxpool_ready)
                    state_d = (op_num == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (!maxpool_ready)
                    state_d = ST_IDLE;
                else if (pop && last_elem)
                    state_d = ST_OUT;
            end
            ST_OUT: begin
                if (!maxpool_ready)
                    state_d = ST_IDLE;
                else if (accept)
                    state_d = (out_cnt_inc == op_q) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                if (!maxpool_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, window accumulator, counters and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q    <= 8'd1;
            op_q     <= '0;
            elem_cnt <= '0;
            out_cnt  <= '0;
            acc      <= '0;
            dout     <= '0;
        end else begin
            if ((state_q == ST_IDLE) && maxpool_ready) begin
                win_q <= (win_len == 8'd0) ? 8'd1 : win_len;
                op_q  <= op_num;
            end
            if (state_d == ST_IDLE) begin
                // Entry to IDLE (normal or abort) discards any partial window.
                elem_cnt <= '0;
                out_cnt  <= '0;
            end else begin
                if (pop) begin
                    acc      <= max_next;
                    elem_cnt <= last_elem ? 8'd0 : (elem_cnt + 8'd1);
                    if (last_elem)
                        dout <= result;
                end
                if (accept)
                    out_cnt <= out_cnt_inc;
            end
        end
    end

    assign maxpool_valid   = (state_q == ST_DONE);
    assign data_fifo_rd_en = (state_q == ST_RUN);
    assign dout_valid      = (state_q == ST_OUT);
    assign state_dbg       = state_q;

endmodule
